// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from a TX FIFO and serialises them as UART frames, LSB first.
// The default build sends 8N1 frames. Defining FIFO_UART_TX_PARITY_EN inserts an even-parity bit,
// which gives 8E1 frames.
//
// Ports:
//   clk        - system clock; all logic is on its rising edge
//   rst        - asynchronous, active-low reset
//   fifo_empty - FIFO empty flag
//   fifo_dout  - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en - FIFO read strobe, a single-cycle pulse per frame
//   serial_out - UART TX line, registered, idles high
//   busy       - high from the pop cycle through the end of the stop bit
//
// Frame timeline: POP (1 cycle), LOAD (1 cycle), START, DATA x WIDTH, [PARITY], STOP.
// Each line symbol lasts SYMBOL_EDGE_TIME cycles.

module fifo_uart_tx #(
    parameter int unsigned CLOCK_FREQ          = 125_000_000,
    parameter int unsigned BAUD_RATE           = 115_200,
    parameter int unsigned WIDTH               = 8,
    parameter int unsigned SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE,
    parameter int unsigned CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             serial_out,
    output logic             busy
);

    localparam int unsigned BIT_CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] BAUD_LAST =
        CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [BIT_CNT_WIDTH-1:0] BIT_LAST = BIT_CNT_WIDTH'(WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle, StPop, StLoad, StStart, StData, StParity, StStop
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StPop, StLoad, StStart, StData, StStop
    } state_e;
`endif

    state_e                         state_q, state_d;
    logic [CLOCK_COUNTER_WIDTH-1:0] baud_q, baud_d;
    logic [BIT_CNT_WIDTH-1:0]       bit_q, bit_d;
    logic [WIDTH-1:0]               shift_q, shift_d;
    logic                           serial_q, serial_d;
    logic                           rd_en;
    logic                           baud_last;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                           parity_q, parity_d;
`endif

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        rd_en    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                // The baud counter is held cleared so it never free-runs while idle.
                baud_d   = '0;
                serial_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = StPop;
                end
            end

            StPop: begin
                baud_d = '0;
                // The read strobe is gated with empty so that a read is never issued into an
                // empty FIFO, even if the flag changed since the state was entered.
                if (fifo_empty) begin
                    state_d = StIdle;
                end else begin
                    rd_en   = 1'b1;
                    state_d = StLoad;
                end
            end

            StLoad: begin
                // The popped word is on fifo_dout now; the start bit goes out next cycle.
                baud_d   = '0;
                bit_d    = '0;
                shift_d  = fifo_dout;
                serial_d = 1'b0;
                state_d  = StStart;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^fifo_dout;
`endif
            end

            StStart: begin
                if (baud_last) begin
                    baud_d   = '0;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                    state_d  = StData;
                end
            end

            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        serial_d = parity_q;
                        state_d  = StParity;
`else
                        serial_d = 1'b1;
                        state_d  = StStop;
`endif
                    end else begin
                        bit_d    = bit_q + 1'b1;
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            StParity: begin
                if (baud_last) begin
                    baud_d   = '0;
                    serial_d = 1'b1;
                    state_d  = StStop;
                end
            end
`endif

            StStop: begin
                if (baud_last) begin
                    baud_d   = '0;
                    serial_d = 1'b1;
                    // Chain straight into the next frame when data is waiting.
                    state_d  = fifo_empty ? StIdle : StPop;
                end
            end

            default: begin
                baud_d   = '0;
                serial_d = 1'b1;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign fifo_rd_en = rd_en;
    assign serial_out = serial_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx.
// A behavioural FIFO feeds the DUT. Each byte pushed into that FIFO is also queued as an expected
// frame. A UART receiver samples the line at mid-bit and compares every frame it decodes against
// the head of that queue.

module tb_fifo_uart_tx;

    localparam int T = 125_000_000 / 115_200;  // 1085 cycles per bit
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en;
    logic       serial_out;
    logic       busy;

    fifo_uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .serial_out (serial_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO.
    logic [7:0] mem [64];
    logic [5:0] wr_ptr = '0;
    logic [5:0] rd_ptr = '0;
    logic       empty_force = 1'b0;

    always_comb fifo_empty = empty_force || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 6'd1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors
    int rd_cnt = 0, low_cnt = 0, busy_cnt = 0, viol = 0;
    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
        if (serial_out === 1'b0) low_cnt <= low_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (fifo_rd_en === 1'b1 && fifo_empty === 1'b1) viol <= viol + 1;
    end

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] exp_q [$];
    int start_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 6'd1;
        exp_q.push_back(b);
    endtask

    task automatic wait_pop(output int c);
        int n;
        n = 0;
        c = -1;
        while (n < 20 && c < 0) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) c = cyc;
            n++;
        end
        if (c < 0) check("pop_timeout", 0, 1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Receiver helper: wait n falling edges; ok drops if reset is seen.
    task automatic rx_wait(input int n, inout bit ok);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst !== 1'b1) ok = 0;
        end
    endtask

    initial begin : rx
        bit         ok;
        logic [7:0] b;
        logic [7:0] e;
        logic       par;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && serial_out === 1'b0) begin
                ok = 1;
                b = '0;
                par = 1'b0;
                start_q.push_back(cyc);
                rx_wait(T / 2, ok);
                if (ok) check("rx_start", serial_out, 0);
                for (int k = 0; k < 8; k++) begin
                    if (ok) rx_wait(T, ok);
                    if (ok) b[k] = serial_out;
                end
`ifdef FIFO_UART_TX_PARITY_EN
                if (ok) rx_wait(T, ok);
                if (ok) par = serial_out;
`endif
                if (ok) rx_wait(T, ok);
                if (ok) begin
                    check("rx_stop", serial_out, 1);
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected", {24'h0, b}, 32'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", b, e);
`ifdef FIFO_UART_TX_PARITY_EN
                        check("rx_parity", par, ^e);
`endif
                    end
                end else begin
                    while (rst !== 1'b1) @(negedge clk);
                end
            end
        end
    end

    initial begin : watchdog
        #(10 * 99000);
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int pc, bc, pushc, r0, l0, b0;
        bit done;

        // Reset state and a long idle period with an empty FIFO
        repeat (5) @(negedge clk);
        check("rst_serial", serial_out, 1);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_low", low_cnt, 0);
        check("idle_busy", busy_cnt, 0);
        check("idle_rd", rd_cnt, 0);

        // Single frame 0x55: pop latency, start offset, busy length
        start_q.delete();
        pushc = cyc;
        push_byte(8'h55);
        wait_pop(pc);
        check("pop_latency", pc - pushc, 1);
        check("busy_at_pop", busy, 1);
        bc = -1;
        for (int n = 0; n < 20000 && bc < 0; n++) begin
            @(negedge clk);
            if (busy === 1'b0) bc = cyc;
        end
        check("busy_len", bc - pc, 2 + NB * T);
        drain("drain_55");
        check("rd_cnt_55", rd_cnt, 1);
        check("start_cnt_55", start_q.size(), 1);
        if (start_q.size() > 0) check("start_offset", start_q[0] - pc, 2);

        // Three back-to-back frames
        start_q.delete();
        r0 = rd_cnt;
        push_byte(8'hA3);
        push_byte(8'h0F);
        push_byte(8'hFF);
        drain("drain_b2b");
        check("rd_cnt_b2b", rd_cnt - r0, 3);
        check("start_cnt_b2b", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("gap_1", start_q[1] - start_q[0], NB * T + 2);
            check("gap_2", start_q[2] - start_q[1], NB * T + 2);
        end

        // Reset in the middle of data bit 4 of 0x3C
        push_byte(8'h3C);
        wait_pop(pc);
        repeat (2 + T / 2 + 5 * T) @(negedge clk);
        check("pre_rst_bit4", serial_out, 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("async_rst_serial", serial_out, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_rd_en", fifo_rd_en, 0);
        repeat (5) @(negedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());  // the popped word is lost
        r0 = rd_cnt;
        l0 = low_cnt;
        b0 = busy_cnt;
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        check("post_rst_rd", rd_cnt - r0, 0);
        check("post_rst_low", low_cnt - l0, 0);
        check("post_rst_busy", busy_cnt - b0, 0);

        // fifo_empty toggling during a frame, with a write while the frame is in flight
        r0 = rd_cnt;
        push_byte(8'h81);
        wait_pop(pc);
        push_byte(8'h42);
        done = 0;
        for (int n = 0; n < 9 * T; n++) begin
            @(negedge clk);
            if (n % 50 == 0) empty_force = ~empty_force;
        end
        empty_force = 1'b0;
        check("rd_during_frame", rd_cnt - r0, 1);
        drain("drain_toggle");
        check("rd_cnt_toggle", rd_cnt - r0, 2);

        check("rd_while_empty", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
